// File: rtl/alu_nibble_sequencer.sv
// Issues one wide ALU/shift operation to a shared 4-bit datapath slice, nibble by nibble,
// chaining carries and assembling the shifter outputs into a wide valid/ready response.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic                   cmd_cin,
    input  logic [4*NIBBLES-1:0]   cmd_a,
    input  logic [4*NIBBLES-1:0]   cmd_b,
    input  logic [1:0]             cmd_shift,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_s,
    output logic                   alu_cin,
    output logic [1:0]             sh_h,
    input  logic [3:0]             dp_o,
    input  logic                   dp_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_data,
    output logic                   rsp_cout,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and its payload stable until that edge.

    state_t        state;
    logic [IW-1:0] idx;
    logic [2:0]    cnt;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;

    assign cmd_ready = (state == IDLE) && !reset;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_cout  = carry;
    assign dbg_state = state;

    // The alu_* registers are loaded on the edge that enters ISSUE, so the slice sees the
    // nibble for the whole ISSUE cycle and the ALU_LAT count starts there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s    <= '0;
            alu_cin  <= 1'b0;
            sh_h     <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_reg   <= cmd_a;
                        b_reg   <= cmd_b;
                        idx     <= '0;
                        alu_a   <= cmd_a[3:0];
                        alu_b   <= cmd_b[3:0];
                        alu_s   <= cmd_op;
                        alu_cin <= cmd_cin;
                        sh_h    <= cmd_shift;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 3'(ALU_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rsp_data[idx*4 +: 4] <= dp_o;
                        carry                <= dp_cout;
                        if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            alu_a   <= a_reg[(idx+1)*4 +: 4];
                            alu_b   <= b_reg[(idx+1)*4 +: 4];
                            alu_cin <= dp_cout;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: three configurations (4x1, 4x3, 1x1), each with its own
// behavioural datapath slice, driven from a vector table plus hand-written corner sequences.
module tb_alu_nibble_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid [3];
    logic        cmd_ready [3];
    logic [2:0]  cmd_op    [3];
    logic        cmd_cin   [3];
    logic [15:0] cmd_a     [3];
    logic [15:0] cmd_b     [3];
    logic [1:0]  cmd_shift [3];
    logic [3:0]  alu_a     [3];
    logic [3:0]  alu_b     [3];
    logic [2:0]  alu_s     [3];
    logic        alu_cin   [3];
    logic [1:0]  sh_h      [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [15:0] rsp_data  [3];
    logic        rsp_cout  [3];
    logic        busy      [3];
    logic [1:0]  dbg_state [3];

    int nib_of [3] = '{4, 4, 1};
    int lat_of [3] = '{1, 3, 1};

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int NB = (g == 2) ? 1 : 4;
        localparam int LT = (g == 1) ? 3 : 1;
        localparam int W  = 4 * NB;

        logic [W-1:0] rd;
        logic [3:0]   aa, ab, o;
        logic [2:0]   s;
        logic [1:0]   h, st;
        logic         ci, co, rv, rc, bz, cr;
        logic [4:0]   sum;
        logic [4:0]   pipe [LT];

        alu_nibble_sequencer #(.NIBBLES(NB), .ALU_LAT(LT)) u_dut (
            .clk(clk), .reset(reset),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cr),
            .cmd_op(cmd_op[g]), .cmd_cin(cmd_cin[g]),
            .cmd_a(cmd_a[g][W-1:0]), .cmd_b(cmd_b[g][W-1:0]), .cmd_shift(cmd_shift[g]),
            .alu_a(aa), .alu_b(ab), .alu_s(s), .alu_cin(ci), .sh_h(h),
            .dp_o(o), .dp_cout(co),
            .rsp_valid(rv), .rsp_ready(rsp_ready[g]), .rsp_data(rd), .rsp_cout(rc),
            .busy(bz), .dbg_state(st)
        );

        // Slice model: S=000 adds, other ops XOR with no carry; H=00 passes F, else rotate left.
        always_comb begin
            sum = 5'd0;
            if (s == 3'b000) sum = {1'b0, aa} + {1'b0, ab} + {4'd0, ci};
            else             sum = {1'b0, aa ^ ab};
        end

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < LT; i++) pipe[i] <= 5'd0;
            end else begin
                pipe[0] <= sum;
                for (int i = 1; i < LT; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign o  = (h == 2'b00) ? pipe[LT-1][3:0] : {pipe[LT-1][2:0], pipe[LT-1][3]};
        assign co = pipe[LT-1][4];

        assign cmd_ready[g] = cr;
        assign alu_a[g]     = aa;
        assign alu_b[g]     = ab;
        assign alu_s[g]     = s;
        assign alu_cin[g]   = ci;
        assign sh_h[g]      = h;
        assign rsp_valid[g] = rv;
        assign rsp_data[g]  = 16'(rd);
        assign rsp_cout[g]  = rc;
        assign busy[g]      = bz;
        assign dbg_state[g] = st;
    end

    typedef struct {
        int          g;
        logic [2:0]  op;
        logic [1:0]  sh;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
        logic        exp_cout;
    } vec_t;

    vec_t        tbl [11];
    logic [16:0] exp_q [$];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_add(input int nib, input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        logic [16:0] m, s;
        m = (17'd1 << (4 * nib)) - 17'd1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + 17'(cin);
        return {s[4*nib], s[15:0] & m[15:0]};
    endfunction

    // Carry expected into nibble k: carry-out of the low k nibbles of the wide add.
    function automatic logic exp_cin(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input int k);
        logic [16:0] m, s;
        if (k == 0) return cin;
        if (op != 3'b000) return 1'b0;
        m = (17'd1 << (4 * k)) - 17'd1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + 17'(cin);
        return s[4*k];
    endfunction

    task automatic do_cmd(input int g, input logic [2:0] op, input logic [1:0] sh, input logic cin,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_data,
                          input logic exp_cout, input int hold, output int waited);
        int          n, l;
        logic [3:0]  ea, eb;
        logic [16:0] got, exp;
        n = nib_of[g];
        l = lat_of[g];
        cmd_op[g] = op; cmd_shift[g] = sh; cmd_cin[g] = cin; cmd_a[g] = a; cmd_b[g] = b;
        cmd_valid[g] = 1'b1;
        waited = 0;
        while (!cmd_ready[g] && waited < 100) begin
            tick();
            waited++;
        end
        if (!cmd_ready[g]) begin
            check("accept_timeout", 32'(cmd_ready[g]), 32'd1);
            cmd_valid[g] = 1'b0;
            return;
        end
        tick();
        cmd_valid[g] = 1'b0;
        exp_q.push_back({exp_cout, exp_data});
        for (int k = 0; k < n; k++) begin
            ea = 4'((a >> (4 * k)) & 16'hF);
            eb = 4'((b >> (4 * k)) & 16'hF);
            check("issue_alu_a", 32'(alu_a[g]), 32'(ea));
            check("issue_alu_b", 32'(alu_b[g]), 32'(eb));
            check("issue_alu_s", 32'(alu_s[g]), 32'(op));
            check("issue_sh_h", 32'(sh_h[g]), 32'(sh));
            check("issue_alu_cin", 32'(alu_cin[g]), 32'(exp_cin(op, a, b, cin, k)));
            check("issue_rsp_valid", 32'(rsp_valid[g]), 32'd0);
            for (int j = 0; j < l; j++) begin
                tick();
                check("wait_alu_ab", {24'd0, alu_a[g], alu_b[g]}, {24'd0, ea, eb});
                check("wait_busy", 32'(busy[g]), 32'd1);
            end
            tick();
        end
        check("rsp_latency", 32'(rsp_valid[g]), 32'd1);
        if (!rsp_valid[g]) begin
            for (int t = 0; t < 50 && !rsp_valid[g]; t++) tick();
            if (!rsp_valid[g]) begin
                check("rsp_timeout", 32'(rsp_valid[g]), 32'd1);
                void'(exp_q.pop_front());
                return;
            end
        end
        if (hold > 0) cmd_valid[g] = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_rsp_valid", 32'(rsp_valid[g]), 32'd1);
            check("hold_rsp_data", {15'd0, rsp_cout[g], rsp_data[g]}, {15'd0, exp_cout, exp_data});
            check("hold_cmd_ready", 32'(cmd_ready[g]), 32'd0);
            check("hold_busy", 32'(busy[g]), 32'd1);
        end
        rsp_ready[g] = 1'b1;
        got = {rsp_cout[g], rsp_data[g]};
        tick();
        rsp_ready[g] = 1'b0;
        exp = exp_q.pop_front();
        check("rsp_data", 32'(got[15:0]), 32'(exp[15:0]));
        check("rsp_cout", 32'(got[16]), 32'(exp[16]));
        check("post_hs_rsp_valid", 32'(rsp_valid[g]), 32'd0);
        check("post_hs_cmd_ready", 32'(cmd_ready[g]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          g;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] e;

        for (int i = 0; i < 3; i++) begin
            cmd_valid[i] = 1'b0; cmd_op[i] = '0; cmd_cin[i] = 1'b0; cmd_a[i] = '0;
            cmd_b[i] = '0; cmd_shift[i] = '0; rsp_ready[i] = 1'b0;
        end

        //           g  op      sh     cin   a         b         data      cout
        tbl[0]  = '{0, 3'b000, 2'b00, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0};
        tbl[1]  = '{0, 3'b000, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[2]  = '{0, 3'b000, 2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0};
        tbl[3]  = '{0, 3'b000, 2'b00, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
        tbl[4]  = '{0, 3'b000, 2'b00, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        tbl[5]  = '{0, 3'b000, 2'b00, 1'b0, 16'h00FF, 16'h0F01, 16'h1000, 1'b0};
        tbl[6]  = '{0, 3'b110, 2'b00, 1'b1, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0};
        tbl[7]  = '{0, 3'b000, 2'b01, 1'b0, 16'h1234, 16'h1111, 16'h468A, 1'b0};
        tbl[8]  = '{1, 3'b000, 2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0};
        tbl[9]  = '{1, 3'b000, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[10] = '{2, 3'b000, 2'b00, 1'b1, 16'h000F, 16'h0001, 16'h0001, 1'b1};

        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("reset_cmd_ready", 32'(cmd_ready[i]), 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("reset_alu", {19'd0, alu_a[i], alu_b[i], alu_s[i], alu_cin[i], sh_h[i]}, 32'd0);
            check("reset_rsp", {15'd0, rsp_cout[i], rsp_data[i]}, 32'd0);
            check("reset_state", 32'(dbg_state[i]), 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check("post_reset_cmd_ready", 32'(cmd_ready[i]), 32'd1);

        for (int i = 0; i < 11; i++)
            do_cmd(tbl[i].g, tbl[i].op, tbl[i].sh, tbl[i].cin, tbl[i].a, tbl[i].b,
                   tbl[i].exp_data, tbl[i].exp_cout, 0, w);

        // Response back-pressure with a waiting command, then back-to-back acceptance.
        do_cmd(0, 3'b000, 2'b00, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 5, w);
        do_cmd(0, 3'b000, 2'b00, 1'b0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0, 0, w);
        check("accept_after_hs", 32'(w), 32'd0);

        for (int r = 0; r < 6; r++) begin
            g  = r % 3;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            e  = ref_add(nib_of[g], ra, rb, rc);
            do_cmd(g, 3'b000, 2'b00, rc, ra, rb, e[15:0], e[16], 0, w);
        end

        // Reset while nibble 2 is in WAIT: everything clears and no response appears.
        cmd_op[0] = 3'b110; cmd_shift[0] = 2'b01; cmd_cin[0] = 1'b1;
        cmd_a[0] = 16'h1234; cmd_b[0] = 16'h5678; cmd_valid[0] = 1'b1;
        tick();
        cmd_valid[0] = 1'b0;
        repeat (5) tick();
        check("midop_busy", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("midop_reset_alu", {19'd0, alu_a[0], alu_b[0], alu_s[0], alu_cin[0], sh_h[0]}, 32'd0);
        check("midop_reset_rsp", {14'd0, rsp_valid[0], rsp_cout[0], rsp_data[0]}, 32'd0);
        check("midop_reset_busy", 32'(busy[0]), 32'd0);
        check("midop_reset_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midop_release_cmd_ready", 32'(cmd_ready[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midop_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        do_cmd(0, 3'b000, 2'b00, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 0, w);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
